reaction_timer_n: RTL and testbench

- Multi-channel reaction-time tester for the DE-board lab designs.
- Sequence: after the player arms it, waits a pseudo-random delay, lights one of `CHANNELS` LEDs, then counts elapsed time in BCD ticks until the matching key is pressed.
- False starts and wrong keys are flagged.
- Sits between the board I/O (keys, switch, LEDs) and the existing decimal 7-segment decoders, which consume its BCD digits.

---
 rtl/reaction_timer_n.sv | 180 ++++++++++++++++++
 tb/tb_reaction_timer_n.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_n.sv
// reaction_timer_n: arm, random wait, light one of CHANNELS LEDs, time the matching key in BCD ticks.
// Define RT_BEST_TIME_EN to add the best_bcd best-time register and port.
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | disarmed; led off, bcd cleared
// S_WAIT  | counting the random delay; any press is a false start
// S_RUN   | target LED lit, bcd counting ticks
// S_DONE  | correct key pressed; bcd frozen, LED stays lit
// S_FAULT | false start or wrong key; all LEDs lit, bcd frozen
module reaction_timer_n #(
  parameter int CHANNELS   = 4,
  parameter int DIGITS     = 4,
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 10,
  parameter int MIN_DELAY  = 10,
  parameter int SPAN_DELAY = 20
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                arm,
  input  logic [CHANNELS-1:0] key_n,
  output logic [CHANNELS-1:0] led,
  output logic [4*DIGITS-1:0] bcd,
  output logic [2:0]          state,
`ifdef RT_BEST_TIME_EN
  output logic [4*DIGITS-1:0] best_bcd,
`endif
  output logic                fault
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW  = $clog2(MIN_DELAY + SPAN_DELAY + 1);
  localparam int BW  = 4 * DIGITS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic                arm_s1, arm_s2;
  logic [CHANNELS-1:0] key_s1, key_s2, key_d;
  logic [15:0]         lfsr_q;
  logic [PW-1:0]       presc_q;
  logic [DW-1:0]       delay_q;
  logic [TW-1:0]       target_q;
  logic [BW-1:0]       bcd_q, bcd_inc;
  logic [CHANNELS-1:0] press, tgt_mask;
  logic                tick, delay_last, any_press, good_press, carry;

  // Keys idle high, so synchronisers reset released to avoid a spurious press
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      arm_s1 <= 1'b0;
      arm_s2 <= 1'b0;
      key_s1 <= '1;
      key_s2 <= '1;
      key_d  <= '1;
      lfsr_q <= 16'hACE1;
    end else begin
      arm_s1 <= arm;
      arm_s2 <= arm_s1;
      key_s1 <= key_n;
      key_s2 <= key_s1;
      key_d  <= key_s2;
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign press      = key_d & ~key_s2;
  assign any_press  = |press;
  assign tgt_mask   = CHANNELS'(1) << target_q;
  assign good_press = (press == tgt_mask) && ((~key_s2 & ~tgt_mask) == '0);
  assign tick       = (presc_q == PW'(DIV - 1));
  assign delay_last = (delay_q <= DW'(1));

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!arm_s2) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_WAIT;
        S_WAIT:  if (any_press) state_d = S_FAULT;
                 else if (tick && delay_last) state_d = S_RUN;
        S_RUN:   if (any_press) state_d = good_press ? S_DONE : S_FAULT;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    led   = '0;
    fault = 1'b0;
    state = state_q;
    case (state_q)
      S_RUN, S_DONE: led = tgt_mask;
      S_FAULT: begin
        led   = '1;
        fault = 1'b1;
      end
      default: led = '0;
    endcase
  end

  // Decimal increment that sticks at all nines
  always_comb begin
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (carry) bcd_inc = bcd_q;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q  <= '0;
      delay_q  <= '0;
      target_q <= '0;
      bcd_q    <= '0;
    end else begin
      if (state_d == state_q && (state_q == S_WAIT || state_q == S_RUN) && !tick)
        presc_q <= presc_q + PW'(1);
      else
        presc_q <= '0;

      if (state_q == S_IDLE && state_d == S_WAIT) begin
        delay_q  <= DW'(MIN_DELAY + (32'(lfsr_q[7:0]) % SPAN_DELAY));
        target_q <= TW'(32'(lfsr_q[15:8]) % CHANNELS);
      end else if (state_q == S_WAIT && tick && !delay_last) begin
        delay_q <= delay_q - DW'(1);
      end

      // A wrong press freezes the pre-tick value; a correct press takes the tick
      if (state_d == S_IDLE)
        bcd_q <= '0;
      else if (state_q == S_RUN && tick && state_d != S_FAULT)
        bcd_q <= bcd_inc;
    end
  end

  assign bcd = bcd_q;

`ifdef RT_BEST_TIME_EN
  logic [BW-1:0] best_q, bcd_final;

  // Packed BCD digits compare correctly as plain binary
  assign bcd_final = tick ? bcd_inc : bcd_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)
      best_q <= {DIGITS{4'h9}};
    else if (state_q == S_RUN && state_d == S_DONE && bcd_final < best_q)
      best_q <= bcd_final;
  end

  assign best_bcd = best_q;
`endif

endmodule

// File: tb/tb_reaction_timer_n.sv
// Testbench for reaction_timer_n: directed round table plus randomized rounds against a round-level model.
`timescale 1ns/1ps
module tb_reaction_timer_n;
  localparam int CH     = 4;
  localparam int DG     = 2;
  localparam int MIN_D  = 2;
  localparam int SPAN_D = 3;
  localparam int DIV    = 10;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd1, ST_RUN = 3'd2,
                         ST_DONE = 3'd3, ST_FAULT = 3'd4;

  typedef enum int {K_TGT, K_WRONG, K_BOTH, K_WAIT, K_ABORT} kind_t;
  typedef struct {
    kind_t      kind;
    int         ticks;
    int         off;
    logic [2:0] exp_state;
    logic [7:0] exp_bcd;
  } vec_t;

  logic          CLOCK_50, RESET_N, arm;
  logic [CH-1:0] key_n;
  logic [CH-1:0] led;
  logic [4*DG-1:0] bcd;
  logic [2:0]    state;
  logic          fault;
`ifdef RT_BEST_TIME_EN
  logic [4*DG-1:0] best_bcd;
`endif

  int          n_checks, n_fail;
  int          cyc;
  logic [15:0] lfsr_m;
  int          best_m;
  vec_t        tbl [10];

  reaction_timer_n #(
    .CHANNELS(CH), .DIGITS(DG), .CLK_HZ(100), .TICK_HZ(10),
    .MIN_DELAY(MIN_D), .SPAN_DELAY(SPAN_D)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .arm     (arm),
    .key_n   (key_n),
    .led     (led),
    .bcd     (bcd),
    .state   (state),
`ifdef RT_BEST_TIME_EN
    .best_bcd(best_bcd),
`endif
    .fault   (fault)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Cycle count since reset release and the reference LFSR sequence
  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cyc    <= 0;
      lfsr_m <= 16'hACE1;
    end else begin
      cyc    <= cyc + 1;
      lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] to_bcd(input int v);
    int s;
    s = (v > 99) ? 99 : v;
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    if (cyc > c) begin
      n_fail++;
      $display("FAIL schedule: at cycle %0d, wanted cycle %0d", cyc, c);
    end
    while (cyc < c) @(negedge CLOCK_50);
  endtask

  // Round-level outcome: ticks elapsed before the event decide bcd, kind decides the end state
  task automatic model_outcome(input kind_t k, input int ticks,
                               output logic [2:0] st, output logic [7:0] b);
    case (k)
      K_TGT:           begin st = ST_DONE;  b = to_bcd(ticks); end
      K_WRONG, K_BOTH: begin st = ST_FAULT; b = to_bcd(ticks); end
      K_WAIT:          begin st = ST_FAULT; b = 8'h00;         end
      default:         begin st = ST_IDLE;  b = 8'h00;         end
    endcase
  endtask

  // Entered at a negedge with the DUT idle (or just out of reset) and arm about to be high
  task automatic run_round(input vec_t v, input int wait_r);
    int e_wait, e_run, d, tgt, p3, mid, other;
    logic [CH-1:0] kmask, exp_led;
    arm = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("idle_before_wait", state, ST_IDLE);
    d     = MIN_D + int'(lfsr_m[7:0]) % SPAN_D;
    tgt   = int'(lfsr_m[15:8]) % CH;
    other = (tgt + 1 + int'($urandom_range(0, CH - 2))) % CH;
    @(negedge CLOCK_50);
    e_wait = cyc;
    e_run  = e_wait + DIV * d;
    chk("wait_entry", state, ST_WAIT);
    chk("wait_led", led, 0);
    kmask = '0;
    if (v.kind == K_WAIT) begin
      p3    = e_wait + wait_r + 3;
      kmask = CH'(1) << $urandom_range(0, CH - 1);
    end else begin
      wait_to(e_run - 1);
      chk("wait_hold", state, ST_WAIT);
      @(negedge CLOCK_50);
      chk("run_entry", state, ST_RUN);
      chk("run_led", led, 32'(CH'(1) << tgt));
      chk("run_bcd_zero", bcd, 0);
      p3  = e_run + DIV * v.ticks + v.off;
      mid = e_run + DIV * (v.ticks / 2) + 5;
      if (mid < p3 - 3) begin
        wait_to(mid);
        chk("run_mid_bcd", bcd, to_bcd(v.ticks / 2));
      end
      case (v.kind)
        K_TGT:   kmask = CH'(1) << tgt;
        K_WRONG: kmask = CH'(1) << other;
        K_BOTH:  kmask = (CH'(1) << tgt) | (CH'(1) << other);
        default: kmask = '0;
      endcase
    end
    wait_to(p3 - 3);
    if (v.kind == K_ABORT) arm = 1'b0;
    else                   key_n = ~kmask;
    wait_to(p3 - 1);
    chk("pre_event_state", state, (v.kind == K_WAIT) ? ST_WAIT : ST_RUN);
    wait_to(p3);
    chk("end_state", state, v.exp_state);
    chk("end_bcd", bcd, v.exp_bcd);
    chk("end_fault", fault, (v.exp_state == ST_FAULT));
    exp_led = (v.exp_state == ST_FAULT) ? {CH{1'b1}} :
              (v.exp_state == ST_DONE)  ? CH'(1) << tgt : '0;
    chk("end_led", led, exp_led);
    if (v.exp_state == ST_DONE && v.ticks < best_m) best_m = (v.ticks > 99) ? 99 : v.ticks;
`ifdef RT_BEST_TIME_EN
    chk("best_bcd", best_bcd, to_bcd(best_m));
`endif
    key_n = '1;
    if (v.kind != K_ABORT) begin
      repeat (100) @(negedge CLOCK_50);
      chk("hold_state", state, v.exp_state);
      chk("hold_bcd", bcd, v.exp_bcd);
      chk("hold_led", led, exp_led);
      arm = 1'b0;
      wait_to(cyc + 2);
      chk("abort_latency", state, v.exp_state);
      @(negedge CLOCK_50);
      chk("abort_state", state, ST_IDLE);
      chk("abort_led", led, 0);
      chk("abort_bcd", bcd, 0);
      chk("abort_fault", fault, 0);
    end
    repeat (2) @(negedge CLOCK_50);
  endtask

  initial begin
    vec_t v;
    int   wr;
    n_checks = 0;
    n_fail   = 0;
    best_m   = 99;
    RESET_N  = 1'b0;
    arm      = 1'b1;
    key_n    = '1;

    tbl[0] = '{K_TGT,   45,  0, ST_DONE,  8'h45};
    tbl[1] = '{K_TGT,   23,  4, ST_DONE,  8'h23};
    tbl[2] = '{K_TGT,   31,  9, ST_DONE,  8'h31};
    tbl[3] = '{K_TGT,   37,  0, ST_DONE,  8'h37};
    tbl[4] = '{K_WRONG,  5,  4, ST_FAULT, 8'h05};
    tbl[5] = '{K_BOTH,  12,  6, ST_FAULT, 8'h12};
    tbl[6] = '{K_WAIT,   0,  0, ST_FAULT, 8'h00};
    tbl[7] = '{K_ABORT,  8,  0, ST_IDLE,  8'h00};
    tbl[8] = '{K_TGT,  120,  3, ST_DONE,  8'h99};
    tbl[9] = '{K_TGT,    0,  5, ST_DONE,  8'h00};

    repeat (3) @(negedge CLOCK_50);
    chk("reset_state", state, ST_IDLE);
    chk("reset_led", led, 0);
    chk("reset_bcd", bcd, 0);
    chk("reset_fault", fault, 0);
`ifdef RT_BEST_TIME_EN
    chk("reset_best", best_bcd, 8'h99);
`endif
    RESET_N = 1'b1;

    for (int i = 0; i < 10; i++) run_round(tbl[i], 0);

    for (int r = 0; r < 8; r++) begin
      v.kind  = kind_t'($urandom_range(0, 4));
      v.ticks = $urandom_range(0, 30);
      if (v.kind == K_TGT || v.kind == K_ABORT) v.off = $urandom_range(0, 9);
      else                                      v.off = $urandom_range(1, 9);
      if (v.ticks == 0 && v.off < 3) v.off = 3;
      wr = $urandom_range(0, 16);
      model_outcome(v.kind, v.ticks, v.exp_state, v.exp_bcd);
      run_round(v, wr);
    end

    // Asynchronous reset in the middle of a running round
    arm = 1'b1;
    repeat (3 + DIV * (MIN_D + SPAN_D - 1) + 50) @(negedge CLOCK_50);
    chk("pre_reset_run", state, ST_RUN);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_reset_state", state, ST_IDLE);
    chk("async_reset_led", led, 0);
    chk("async_reset_bcd", bcd, 0);
    chk("async_reset_fault", fault, 0);
`ifdef RT_BEST_TIME_EN
    chk("async_reset_best", best_bcd, 8'h99);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
